// File: rtl/mem_io_responder.sv
// mem_io_responder
//   Memory-mapped responder for the processor's data-memory port. Samples
//   ADDR/DOUT/W every rising edge, returns registered read data one cycle
//   later and commits writes on the same edge.
//   Map (ADDR[15:12]): 0x0 RAM (aliased), 0x1 LEDR, 0x2 synchronized SW,
//   0x3000 timer load, 0x3001 timer count, 0x3002 timer status/clear.
// Ports
//   Clock, Resetn      : clock, asynchronous active-low reset
//   ADDR, DOUT, W      : processor address, write data, write strobe
//   DataFromMemory     : registered read data for the previous ADDR
//   SW                 : asynchronous board switches
//   LEDR               : LED register
//   tmr_done           : timer expired flag, sticky until cleared or reloaded
module mem_io_responder #(
  parameter int RAM_AW   = 8,
  parameter int PRESCALE = 4
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] ADDR,
  input  logic [15:0] DOUT,
  input  logic        W,
  output logic [15:0] DataFromMemory,
  input  logic [9:0]  SW,
  output logic [9:0]  LEDR,
  output logic        tmr_done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    T_IDLE    = 2'd0,
    T_RUN     = 2'd1,
    T_EXPIRED = 2'd2
  } tmr_state_e;

  // Address decode
  logic [3:0] region;
  logic       sel_ram, sel_led, sel_sw, sel_tload, sel_tcount, sel_tstat;

  assign region     = ADDR[15:12];
  assign sel_ram    = (region == 4'h0);
  assign sel_led    = (region == 4'h1);
  assign sel_sw     = (region == 4'h2);
  assign sel_tload  = (ADDR == 16'h3000);
  assign sel_tcount = (ADDR == 16'h3001);
  assign sel_tstat  = (ADDR == 16'h3002);

  // State
  logic [15:0] ram [2**RAM_AW];
  logic [15:0] rdata_q;
  logic [9:0]  led_q;
  logic [9:0]  sw_meta_q, sw_sync_q;
  tmr_state_e  state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [15:0] load_q;
  logic        done_q, done_d;
  logic [15:0] rdata_d;

  // NOTE: the RAM has no reset branch so it maps onto a plain memory macro;
  // contents after power-up are undefined and survive Resetn.
  always_ff @(posedge Clock) begin
    if (W && sel_ram) ram[ADDR[RAM_AW-1:0]] <= DOUT;
  end

  // Read mux sees pre-edge state, so a same-edge write returns the old value.
  always_comb begin
    // NOTE: default assignment first so no path leaves rdata_d unassigned,
    // which would otherwise infer a latch.
    rdata_d = 16'h0000;
    if (sel_ram)         rdata_d = ram[ADDR[RAM_AW-1:0]];
    else if (sel_led)    rdata_d = {6'b0, led_q};
    else if (sel_sw)     rdata_d = {6'b0, sw_sync_q};
    else if (sel_tload)  rdata_d = load_q;
    else if (sel_tcount) rdata_d = count_q;
    else if (sel_tstat)  rdata_d = {15'b0, done_q};
  end

  // Timer next-state
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pcnt_d  = pcnt_q;
    done_d  = done_q;

    if (W && sel_tload) begin
      // Load from any state restarts the timer and clears a pending flag.
      count_d = DOUT;
      pcnt_d  = '0;
      if (DOUT == 16'h0000) begin
        state_d = T_EXPIRED;
        done_d  = 1'b1;
      end else begin
        state_d = T_RUN;
        done_d  = 1'b0;
      end
    end else begin
      if (W && sel_tstat && DOUT[0]) begin
        done_d = 1'b0;
        if (state_q == T_EXPIRED) state_d = T_IDLE;
      end
      // Expiry on the same edge as a clear wins, keeping EXPIRED consistent.
      if (state_q == T_RUN) begin
        if (pcnt_q == PCNT_LAST) begin
          pcnt_d  = '0;
          count_d = count_q - 16'd1;
          if (count_q == 16'd1) begin
            state_d = T_EXPIRED;
            done_d  = 1'b1;
          end
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
    end
  end

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rdata_q   <= '0;
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      state_q   <= T_IDLE;
      count_q   <= '0;
      pcnt_q    <= '0;
      load_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      rdata_q   <= rdata_d;
      sw_meta_q <= SW;
      sw_sync_q <= sw_meta_q;
      state_q   <= state_d;
      count_q   <= count_d;
      pcnt_q    <= pcnt_d;
      done_q    <= done_d;
      if (W && sel_led)   led_q  <= DOUT[9:0];
      if (W && sel_tload) load_q <= DOUT;
    end
  end

  assign DataFromMemory = rdata_q;
  assign LEDR           = led_q;
  assign tmr_done       = done_q;

endmodule
